// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART controller.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP1  = 3'd4,
    TX_STOP2  = 3'd5
  } tx_state_t;

  localparam int unsigned MIN_DIVISOR = 4;

  function automatic parity_mode_t decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Even parity is the XOR of the data bits; odd is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input parity_mode_t mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; level disambiguates full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && valid;
  // A pop frees the slot in the same cycle, so a push on full is still taken.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_fifo_controller.sv
// Full-duplex 8-bit UART with TX/RX FIFOs, optional parity, RTS/CTS and sticky errors.
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH     = 16,
  parameter int unsigned RESET_DIVISOR = 18,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned RX_DEPTH      = 16,
  parameter int unsigned RTS_MARGIN    = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DIV_WIDTH-1:0]         cfg_divisor,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_two_stop,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_pop,
  output logic [$clog2(TX_DEPTH):0]    tx_level,
  output logic [$clog2(RX_DEPTH):0]    rx_level,
  output logic                         err_framing,
  output logic                         err_parity,
  output logic                         err_overrun,
  input  logic                         err_clear,
  input  logic                         uart_rx,
  output logic                         uart_tx,
  input  logic                         cts_n,
  output logic                         rts_n
);

  localparam int unsigned RXLW = $clog2(RX_DEPTH) + 1;

  logic rx_meta, rx_sync, cts_meta, cts_sync;
  logic [DIV_WIDTH-1:0] div_eff;
  parity_mode_t         cfg_mode;

  // Two-flop synchronisers; idle-high so reset looks like an idle line / blocked host.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign div_eff  = (cfg_divisor < DIV_WIDTH'(MIN_DIVISOR)) ? DIV_WIDTH'(MIN_DIVISOR) : cfg_divisor;
  assign cfg_mode = decode_parity(cfg_parity);

  logic [7:0] tx_head;
  logic       tx_head_valid, tx_full, tx_pop;
  logic       rx_push, rx_full;
  logic [7:0] rx_shift_q, rx_shift_d;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
    .head(tx_head), .valid(tx_head_valid), .full(tx_full), .level(tx_level)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .push_data(rx_shift_q), .pop(rx_pop),
    .head(rx_data), .valid(rx_valid), .full(rx_full), .level(rx_level)
  );

  assign tx_ready = ~tx_full;

  // ---------------- Transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
  logic                 tx_two_q, tx_two_d, tx_line_d, tx_frame_end, tx_bit_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= DIV_WIDTH'(RESET_DIVISOR);
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_two_q    <= 1'b0;
      uart_tx     <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_par_en_q <= tx_par_en_d;
      tx_two_q    <= tx_two_d;
      uart_tx     <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q + DIV_WIDTH'(1);
    tx_div_d     = tx_div_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_par_d     = tx_par_q;
    tx_par_en_d  = tx_par_en_q;
    tx_two_d     = tx_two_q;
    tx_pop       = 1'b0;
    tx_frame_end = 1'b0;
    tx_line_d    = 1'b1;
    tx_bit_done  = (tx_cnt_q == tx_div_q - DIV_WIDTH'(1));
    if (tx_bit_done) tx_cnt_d = '0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d     = '0;
        tx_frame_end = 1'b1;
      end
      TX_START:  if (tx_bit_done) tx_state_d = TX_DATA;
      TX_DATA: begin
        if (tx_bit_done) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
        end
      end
      TX_PARITY: if (tx_bit_done) tx_state_d = TX_STOP1;
      TX_STOP1: begin
        if (tx_bit_done) begin
          tx_state_d   = tx_two_q ? TX_STOP2 : TX_IDLE;
          tx_frame_end = ~tx_two_q;
        end
      end
      TX_STOP2: begin
        if (tx_bit_done) begin
          tx_state_d   = TX_IDLE;
          tx_frame_end = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Start from idle or chain straight off the last stop bit; config latched here.
    if (tx_frame_end && tx_head_valid && !cts_sync) begin
      tx_pop      = 1'b1;
      tx_state_d  = TX_START;
      tx_cnt_d    = '0;
      tx_bit_d    = '0;
      tx_shift_d  = tx_head;
      tx_div_d    = div_eff;
      tx_par_en_d = (cfg_mode != PAR_NONE);
      tx_par_d    = parity_bit(tx_head, cfg_mode);
      tx_two_d    = cfg_two_stop;
    end
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_d[0];
      TX_PARITY: tx_line_d = tx_par_d;
      default:   tx_line_d = 1'b1;
    endcase
  end

  // ---------------- Receiver ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  parity_mode_t         rx_mode_q, rx_mode_d;
  logic                 rx_par_bad_q, rx_par_bad_d, rx_bit_done, rx_half_done;
  logic                 set_framing, set_parity, set_overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= DIV_WIDTH'(RESET_DIVISOR);
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_mode_q    <= PAR_NONE;
      rx_par_bad_q <= 1'b0;
      err_framing  <= 1'b0;
      err_parity   <= 1'b0;
      err_overrun  <= 1'b0;
      rts_n        <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_mode_q    <= rx_mode_d;
      rx_par_bad_q <= rx_par_bad_d;
      err_framing  <= (err_framing && !err_clear) || set_framing;
      err_parity   <= (err_parity  && !err_clear) || set_parity;
      err_overrun  <= (err_overrun && !err_clear) || set_overrun;
      rts_n        <= (RXLW'(RX_DEPTH) - rx_level) <= RXLW'(RTS_MARGIN);
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + DIV_WIDTH'(1);
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_mode_d    = rx_mode_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_push      = 1'b0;
    set_framing  = 1'b0;
    set_parity   = 1'b0;
    rx_bit_done  = (rx_cnt_q == rx_div_q - DIV_WIDTH'(1));
    rx_half_done = (rx_cnt_q == (rx_div_q >> 1) - DIV_WIDTH'(1));
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync) begin
          rx_state_d   = RX_START;
          rx_div_d     = div_eff;
          rx_mode_d    = cfg_mode;
          rx_par_bad_d = 1'b0;
        end
      end
      RX_START: begin
        // A line back high at mid-start is a glitch, not a frame.
        if (rx_half_done) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_done) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = (rx_mode_q != PAR_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_bit_done) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = (rx_sync != parity_bit(rx_shift_q, rx_mode_q));
          rx_state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_done) begin
          set_framing = ~rx_sync;
          set_parity  = rx_par_bad_q;
          rx_push     = rx_sync && !rx_par_bad_q;
          rx_state_d  = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign set_overrun = rx_push && rx_full && !rx_pop;

endmodule

// File: tb/tb_uart_fifo_controller.sv
// Scoreboard bench for uart_fifo_controller: serial TX decoder and RX pop monitor check queued expectations.
`timescale 1ns/1ps
module tb_uart_fifo_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_divisor = 16'd8;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_two_stop = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [4:0]  tx_level, rx_level;
  logic        err_framing, err_parity, err_overrun;
  logic        err_clear = 1'b0;
  logic        uart_tx;
  logic        rx_line = 1'b1;
  logic        loopback = 1'b0;
  logic        cts_n = 1'b0;
  logic        rts_n;
  wire         uart_rx = loopback ? uart_tx : rx_line;

  always #5 clock = ~clock;

  uart_fifo_controller dut (
    .clock(clock), .reset(reset), .cfg_divisor(cfg_divisor), .cfg_parity(cfg_parity),
    .cfg_two_stop(cfg_two_stop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_level(tx_level),
    .rx_level(rx_level), .err_framing(err_framing), .err_parity(err_parity),
    .err_overrun(err_overrun), .err_clear(err_clear), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .cts_n(cts_n), .rts_n(rts_n)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par_en;
    logic       par_odd;
    logic       two_stop;
  } frame_t;

  frame_t     tx_q[$];
  frame_t     cur;
  logic [7:0] rx_q[$];
  int         start_cyc[$];
  logic       mon_active = 1'b0;
  logic       auto_pop = 1'b0;
  int         mon_off = 0;
  int         mb, mp;

  function automatic int frame_bits(input frame_t f);
    return 10 + (f.par_en ? 1 : 0) + (f.two_stop ? 1 : 0);
  endfunction

  function automatic logic frame_bit(input frame_t f, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if (b == 9 && f.par_en) return (^f.data) ^ f.par_odd;
    return 1'b1;
  endfunction

  // Serial decoder: checks every bit at its first, middle and last clock.
  always @(negedge clock) begin
    if (reset) begin
      mon_active = 1'b0;
      tx_q.delete();
    end else begin
      if (!mon_active && uart_tx == 1'b0) begin
        check("tx_start_has_frame", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          cur = tx_q.pop_front();
          mon_active = 1'b1;
          mon_off = 0;
          start_cyc.push_back(cyc);
        end
      end
      if (mon_active) begin
        mb = mon_off / cur.div;
        mp = mon_off % cur.div;
        if (mp == 0 || mp == cur.div / 2 || mp == cur.div - 1)
          check($sformatf("tx_d%02h_bit%0d_pos%0d", cur.data, mb, mp), 32'(uart_tx), 32'(frame_bit(cur, mb)));
        mon_off++;
        if (mon_off == frame_bits(cur) * cur.div) mon_active = 1'b0;
      end
    end
  end

  // RX monitor: pops and compares whenever a byte is presented and popping is enabled.
  always @(negedge clock) begin
    rx_pop = 1'b0;
    if (!reset && auto_pop && rx_valid) begin
      check("rx_byte_pending", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0) check("rx_byte", 32'(rx_data), 32'(rx_q.pop_front()));
      rx_pop = 1'b1;
    end
  end

  task automatic push_tx(input logic [7:0] d);
    frame_t f;
    f.data     = d;
    f.div      = (cfg_divisor < 16'd4) ? 4 : int'(cfg_divisor);
    f.par_en   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    f.par_odd  = (cfg_parity == 2'b10);
    f.two_stop = cfg_two_stop;
    @(negedge clock);
    tx_data  = d;
    tx_valid = 1'b1;
    tx_q.push_back(f);
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic v, input int div);
    @(negedge clock);
    rx_line = v;
    repeat (div - 1) @(negedge clock);
  endtask

  task automatic send_serial(input logic [7:0] d, input int div, input logic par_en,
                             input logic par_val, input logic stop_val);
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (par_en) drive_bit(par_val, div);
    drive_bit(stop_val, div);
    @(negedge clock);
    rx_line = 1'b1;
    repeat (div) @(negedge clock);
  endtask

  task automatic wait_tx_done(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || mon_active || tx_level != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_rx_done(input string name, input int budget);
    int n;
    n = 0;
    while (rx_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_rts_n", 32'(rts_n), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_errs", 32'({err_framing, err_parity, err_overrun}), 32'd0);
    repeat (4) @(negedge clock);

    // 0xA5 at D=8, no parity, one stop
    push_tx(8'hA5);
    check("t1_level_after_push", 32'(tx_level), 32'd1);
    check("t1_line_idle_before_start", 32'(uart_tx), 32'd1);
    @(negedge clock);
    check("t1_level_after_pop", 32'(tx_level), 32'd0);
    check("t1_start_low", 32'(uart_tx), 32'd0);
    wait_tx_done("t1_tx_done", 200);
    check("t1_final_level", 32'(tx_level), 32'd0);
    check("t1_line_idle", 32'(uart_tx), 32'd1);

    // Loopback with D=18, even parity
    cfg_divisor = 16'd18;
    cfg_parity  = 2'b01;
    loopback    = 1'b1;
    auto_pop    = 1'b1;
    rx_q.push_back(8'h00); push_tx(8'h00);
    rx_q.push_back(8'hFF); push_tx(8'hFF);
    rx_q.push_back(8'h3C); push_tx(8'h3C);
    wait_tx_done("t2_tx_done", 1500);
    wait_rx_done("t2_rx_done", 200);
    check("t2_errs", 32'({err_framing, err_parity, err_overrun}), 32'd0);
    check("t2_rx_level", 32'(rx_level), 32'd0);
    loopback = 1'b0;
    repeat (40) @(negedge clock);

    // Framing error, clear, good byte, parity error
    cfg_divisor = 16'd8;
    cfg_parity  = 2'b00;
    send_serial(8'h81, 8, 1'b0, 1'b0, 1'b0);
    check("t3_err_framing", 32'(err_framing), 32'd1);
    check("t3_level_after_framing", 32'(rx_level), 32'd0);
    pulse_clear();
    check("t3_framing_cleared", 32'(err_framing), 32'd0);
    rx_q.push_back(8'h55);
    send_serial(8'h55, 8, 1'b0, 1'b0, 1'b1);
    wait_rx_done("t3_rx_55", 100);
    check("t3_errs_after_good", 32'({err_framing, err_parity, err_overrun}), 32'd0);
    cfg_parity = 2'b01;
    send_serial(8'h81, 8, 1'b1, 1'b1, 1'b1);
    check("t3_err_parity", 32'(err_parity), 32'd1);
    check("t3_level_after_parity", 32'(rx_level), 32'd0);
    check("t3_no_framing", 32'(err_framing), 32'd0);
    pulse_clear();
    check("t3_parity_cleared", 32'(err_parity), 32'd0);
    cfg_parity = 2'b00;

    // Fill RX without popping, then overrun
    auto_pop = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      rx_q.push_back(8'(8'h10 + k - 1));
      send_serial(8'(8'h10 + k - 1), 8, 1'b0, 1'b0, 1'b1);
      check($sformatf("t4_level_%0d", k), 32'(rx_level), 32'(k));
      check($sformatf("t4_rts_%0d", k), 32'(rts_n), 32'(k >= 14));
    end
    check("t4_no_overrun_yet", 32'(err_overrun), 32'd0);
    send_serial(8'hEE, 8, 1'b0, 1'b0, 1'b1);
    check("t4_err_overrun", 32'(err_overrun), 32'd1);
    check("t4_level_full", 32'(rx_level), 32'd16);
    check("t4_head_kept", 32'(rx_data), 32'h10);
    auto_pop = 1'b1;
    wait_rx_done("t4_drain", 100);
    repeat (3) @(negedge clock);
    check("t4_level_drained", 32'(rx_level), 32'd0);
    check("t4_rts_released", 32'(rts_n), 32'd0);
    pulse_clear();
    check("t4_overrun_cleared", 32'(err_overrun), 32'd0);

    // CTS hold then back-to-back two-stop frames
    cfg_two_stop = 1'b1;
    @(negedge clock);
    cts_n = 1'b1;
    repeat (4) @(negedge clock);
    push_tx(8'h12);
    push_tx(8'h34);
    push_tx(8'hC7);
    start_cyc.delete();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (uart_tx == 1'b0) lows++;
    end
    check("t5_held_by_cts", 32'(lows), 32'd0);
    check("t5_level_held", 32'(tx_level), 32'd3);
    cts_n = 1'b0;
    wait_tx_done("t5_tx_done", 600);
    check("t5_frame_count", 32'(start_cyc.size()), 32'd3);
    if (start_cyc.size() == 3) begin
      check("t5_gap_1", 32'(start_cyc[1] - start_cyc[0]), 32'd88);
      check("t5_gap_2", 32'(start_cyc[2] - start_cyc[1]), 32'd88);
    end
    cfg_two_stop = 1'b0;
    repeat (10) @(negedge clock);

    // Async reset in the middle of data bit 4
    push_tx(8'h0F);
    push_tx(8'h99);
    lows = 0;
    while (uart_tx !== 1'b0 && lows < 20) begin
      @(negedge clock);
      lows++;
    end
    check("t6_frame_started", 32'(lows < 20), 32'd1);
    repeat (43) @(negedge clock);
    check("t6_bit4_low", 32'(uart_tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("t6_tx_high_async", 32'(uart_tx), 32'd1);
    check("t6_level_cleared", 32'(tx_level), 32'd0);
    check("t6_ready", 32'(tx_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tx_q.delete();
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (uart_tx == 1'b0) lows++;
    end
    check("t6_no_residual_frame", 32'(lows), 32'd0);
    check("t6_level_after", 32'(tx_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_controller.md
Name: uart_fifo_controller

Overview:
- Next-generation serial port for the slow-IO domain. Full-duplex 8-bit UART with runtime baud divisor, optional parity, 1 or 2 stop bits, and TX/RX FIFOs.
- RTS/CTS hardware flow control and sticky error flags.
- Sits between the slow-IO bus glue and the FTDI pins; replaces the unbuffered single-byte serial controller.

Parameters:
- DIV_WIDTH, 16, width of baud divisor (clocks per bit).
- RESET_DIVISOR, 18, divisor value loaded into cfg register at reset.
- TX_DEPTH, 16, TX FIFO entries (power of 2, >=2).
- RX_DEPTH, 16, RX FIFO entries (power of 2, >=4).
- RTS_MARGIN, 2, RX free-entry count at or below which rts_n deasserts (goes high).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_divisor  in  DIV_WIDTH  clocks per bit; values <4 treated as 4.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
- cfg_two_stop  in  1  1 = two stop bits on TX; RX checks only the first.
- tx_data  in  8  byte to enqueue.
- tx_valid  in  1  enqueue strobe; accepted when tx_ready=1.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_pop  in  1  dequeue head; ignored when rx_valid=0.
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- err_framing, err_parity, err_overrun  out  1 each  sticky error flags.
- err_clear  in  1  clears all three flags.
- uart_rx  in  1  serial input (FTDI BD0), asynchronous.
- uart_tx  out  1  serial output (FTDI BD1), idle high.
- cts_n  in  1  FTDI BD2; low = host may receive.
- rts_n  out  1  FTDI BD3; high = stop sending to us.

Behaviour:
- Reset (async): uart_tx=1, rts_n=0, both FIFOs empty, tx_ready=1, rx_valid=0, levels 0, error flags 0, both FSMs IDLE, rx_data=0. The internal divisor register loads RESET_DIVISOR; cfg_divisor is sampled each frame start thereafter.
- Config (divisor, parity, stop bits) is latched at each frame start; mid-frame changes affect the next frame only.
- uart_rx and cts_n pass through a 2-flop synchroniser before use. That latency is included in the tolerances below.
- RX FSM: IDLE -> START -> DATA(8, LSB first) -> PARITY (only if enabled) -> STOP -> IDLE.
  - IDLE: a synchronised low starts a half-bit counter (D/2 clocks). If the line is still low at expiry, go to START-confirmed and sample each subsequent bit every D clocks at mid-bit. If the line is high at expiry, treat it as a glitch and return to IDLE with no error.
  - STOP sampled low: set err_framing and discard the byte. Wait for the line to go high before re-arming.
  - Parity mismatch: set err_parity and discard the byte.
  - Good byte: push to RX FIFO at the stop-sample cycle. If the FIFO is full, drop the byte, set err_overrun, and leave FIFO contents unchanged.
- TX FSM: IDLE -> START -> DATA(8) -> PARITY (if enabled) -> STOP1 -> STOP2 (if cfg_two_stop) -> IDLE. Each state lasts exactly D clocks.
  - Leave IDLE only when the TX FIFO is non-empty and synchronised cts_n=0. The head is popped on the same cycle and uart_tx goes low on the next cycle.
  - cts_n rising mid-frame does not abort the frame; it blocks only the next start.
  - Back-to-back frames: the next START begins immediately after the last stop bit, with no idle gap.
- FIFOs: synchronous, registered output.
  - Push and pop in the same cycle: level unchanged. This is legal even when full (TX) or, for RX, when the pop frees the slot.
  - RX push on full with simultaneous rx_pop: accepted, no overrun.
  - rx_data is valid in the same cycle as rx_valid (first-word-fall-through).
  - Pointers wrap modulo depth; level distinguishes full from empty.
- rts_n is registered: 1 when (RX_DEPTH - rx_level) <= RTS_MARGIN, else 0.
- Error flags: set-dominant over err_clear in the same cycle.
- Parity bit: even = XOR of data bits; odd = its inverse.

Decomposition:
- Package uart_pkg holds:
  - typedef parity_mode_t (PAR_NONE, PAR_EVEN, PAR_ODD).
  - enum rx_state_t, enum tx_state_t.
  - constant MIN_DIVISOR=4.
- One sub-module, sync_fifo (params WIDTH, DEPTH), instantiated twice (TX and RX).
- The 2-flop synchroniser is inline.

Test Plan:
- Byte 0xA5, D=8, no parity, one stop, cts_n=0 -> uart_tx low 8 clocks, then bits 1,0,1,0,0,1,0,1 at 8 clocks each, then high; tx_level returns to 0.
- Loopback uart_tx->uart_rx, D=18, even parity, send 0x00,0xFF,0x3C -> rx_data yields the same 3 bytes in order; no error flags set.
- Inject frame with stop bit = 0 -> err_framing=1, rx_level unchanged. Then pulse err_clear -> flag 0. Then a valid 0x55 is received.
- Fill RX with 16 bytes and no pops -> rts_n=1 at rx_level>=14. The 17th byte sets err_overrun; the head stays the first byte.
- Hold cts_n=1 with 3 bytes queued -> uart_tx stays high. Release cts_n -> 3 frames back-to-back, 2 stop bits each when cfg_two_stop=1.
- Assert reset mid-TX frame (bit 4) -> uart_tx=1 immediately (async). The FIFO empties; after release, no residual frame is emitted.
